rom_stream_seq: RTL and testbench

- Sequencer that reads a block of consecutive words from the single-port synchronous ROM and streams them to the SPI transmit path over a valid/ready handshake.
- Drives the ROM address and captures ROM data, accounting for the ROM's one-cycle registered read latency.
- Sits between the ROM (waveform/lookup table storage) and the SPI master's transmit data input.
- Started by a one-cycle command carrying the base address and length.

---
 rtl/rom_stream_seq.sv | 190 +++++++++++++++++++
 tb/tb_rom_stream_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_seq.sv
// -----------------------------------------------------------------------------
// rom_stream_seq
//
// Reads a block of consecutive words from a single-port synchronous ROM (one
// cycle registered read latency) and streams them to the SPI transmit path
// over a valid/ready handshake. A one-cycle start command carries the base
// address and the word count.
//
// Each word takes three states: ADDR (ROM samples rom_addr), DATA (rom_q is
// valid and is captured into tx_data), SEND (hold tx_data until tx_ready).
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst        in   asynchronous, active-high reset
//   start      in   one-cycle command pulse, accepted only in IDLE
//   abort      in   synchronous abort, returns to IDLE from any state
//   loop       in   (only with ROM_STREAM_SEQ_LOOP_EN) restart the block
//                   after its last word instead of stopping
//   base_addr  in   first ROM address, sampled when start is accepted
//   len        in   number of words, sampled when start is accepted
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last word handshakes
//   rom_addr   out  registered ROM address
//   rom_q      in   ROM read data, valid one cycle after rom_addr is sampled
//   tx_data    out  word presented to the SPI transmitter
//   tx_valid   out  tx_data is valid
//   tx_ready   in   transmitter accepts the word when tx_valid && tx_ready
//
// Optional feature macro: ROM_STREAM_SEQ_LOOP_EN (continuous playback).
// -----------------------------------------------------------------------------
module rom_stream_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
`ifdef ROM_STREAM_SEQ_LOOP_EN
  input  logic                  loop,
`endif
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_SEND = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q,  rom_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
  logic                  tx_valid_q,  tx_valid_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;

`ifdef ROM_STREAM_SEQ_LOOP_EN
  // Block parameters kept for restarting each pass.
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q,  len_d;
`endif

  wire handshake = tx_valid_q && tx_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
`ifdef ROM_STREAM_SEQ_LOOP_EN
    base_d      = base_q;
    len_d       = len_q;
`endif

    if (abort) begin
      // Abort outranks start and handshake; rom_addr deliberately keeps its value.
      state_d     = S_IDLE;
      tx_valid_d  = 1'b0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              rom_addr_d  = base_addr;
              remaining_d = len;
              state_d     = S_ADDR;
`ifdef ROM_STREAM_SEQ_LOOP_EN
              base_d      = base_addr;
              len_d       = len;
`endif
            end else begin
              // Zero-length command completes immediately without a transfer.
              done_d = 1'b1;
            end
          end
        end

        // ROM samples rom_addr at the end of this cycle.
        S_ADDR: state_d = S_DATA;

        S_DATA: begin
          tx_data_d   = rom_q;
          tx_valid_d  = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          state_d     = S_SEND;
        end

        S_SEND: begin
          if (handshake) begin
            tx_valid_d = 1'b0;
            if (remaining_q != '0) begin
              // Wraps naturally modulo 2**ADDR_WIDTH.
              rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
              state_d    = S_ADDR;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
`ifdef ROM_STREAM_SEQ_LOOP_EN
              if (loop) begin
                rom_addr_d  = base_q;
                remaining_d = len_q;
                state_d     = S_ADDR;
              end
`endif
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Registered busy follows the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
`ifdef ROM_STREAM_SEQ_LOOP_EN
      base_q      <= '0;
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
`ifdef ROM_STREAM_SEQ_LOOP_EN
      base_q      <= base_d;
      len_q       <= len_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_rom_stream_seq.sv
// -----------------------------------------------------------------------------
// tb_rom_stream_seq
//
// Self-checking bench for rom_stream_seq. A behavioural ROM returns
// q = addr ^ 8'hA5 one cycle after the address. The reference model is a
// queue of expected words, filled from (base + i) mod 256 for each command
// and drained on every observed handshake. Inputs change 2 time units after
// posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_rom_stream_seq;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
`ifdef ROM_STREAM_SEQ_LOOP_EN
  logic          loop;
`endif
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;

  always #5 clk = ~clk;

  // Behavioural synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_q <= rom_addr ^ 8'hA5;

  rom_stream_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
`ifdef ROM_STREAM_SEQ_LOOP_EN
    .loop      (loop),
`endif
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         hs_cnt       = 0;
  int         done_cnt     = 0;
  int         pass_hs      = 0;
  int         exp_pass_len = 0;
  int         ready_pct    = 100;
  bit         stall        = 1'b0;
  logic [7:0] stall_data   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'((base + i) % 256) ^ 8'hA5);
  endtask

  // Negedge observer: handshakes against the model, stability under
  // backpressure, and the word count of each completed pass.
  task automatic monitor();
    if (rst || abort) begin
      stall   = 1'b0;
      pass_hs = 0;
    end else begin
      if (stall) check("hold_data", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
      stall      = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        pass_hs++;
        if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
        else check("tx_data", tx_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("pass_len", pass_hs, exp_pass_len);
        pass_hs = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
    tx_ready = ($urandom_range(99) < ready_pct);
  endtask

  // One command: stream n words from base with random backpressure. If poke
  // is non-negative, a second start is pulsed while busy at that cycle.
  task automatic run(input int base, input int n, input int pct, input int budget, input int poke);
    int d0, lat;
    bit got;
    d0           = done_cnt;
    exp_pass_len = n;
    ready_pct    = pct;
    push_words(base, n);
    base_addr = AW'(base);
    len       = LW'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = LW'($urandom_range(1, 300));
    check("busy_start", busy, n != 0);
    if (n != 0) begin
      lat = 1;
      while (!tx_valid && lat < 8) begin
        tick();
        lat++;
      end
      check("latency", lat, 3);
    end
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (c == poke);
      tick();
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("busy_after_done", busy, 0);
    check("queue_empty", exp_q.size(), 0);
    tick();
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int b, d0, h0;
    bit got;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    len       = '0;
    tx_ready  = 1'b0;
`ifdef ROM_STREAM_SEQ_LOOP_EN
    loop      = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_data", tx_data, 0);
    rst = 1'b0;
    tick();

    // Basic stream: 0xB5, 0xB4, 0xB7, 0xB6.
    run(8'h10, 4, 100, 100, -1);

    // Wrap across 0xFF -> 0x00 with backpressure.
    run(8'hFE, 3, 50, 200, -1);

    // Zero length: done pulse only.
    run($urandom_range(255), 0, 100, 10, -1);

    // Full ROM from base 0.
    run(0, 256, 90, 4000, -1);

    // Start while busy is ignored.
    run($urandom_range(255), 8, 100, 200, 5);

    // Randomised commands.
    for (int k = 0; k < 10; k++)
      run($urandom_range(255), $urandom_range(1, 20), $urandom_range(30, 100), 400, -1);

    // Abort while word 2 of 8 is presented.
    b  = $urandom_range(255);
    d0 = done_cnt;
    h0 = hs_cnt;
    exp_pass_len = 8;
    ready_pct    = 100;
    push_words(b, 2);
    base_addr = AW'(b);
    len       = LW'(8);
    start     = 1'b1;
    tick();
    start = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (hs_cnt == h0 + 1 && tx_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_reach_word2", got, 1);
    check("abort_word2", tx_data, exp_q.size() != 0 ? exp_q[0] : 8'h00);
    tx_ready = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    for (int c = 0; c < 6; c++) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", busy, 0);

    // Abort and start together in IDLE: abort wins.
    d0 = done_cnt;
    base_addr = 8'h40;
    len       = LW'(3);
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    for (int c = 0; c < 6; c++) tick();
    check("abort_start_no_done", done_cnt - d0, 0);

`ifdef ROM_STREAM_SEQ_LOOP_EN
    // Loop: 0x20, 0x21 for four passes, loop dropped after the third done.
    begin
      int  dn;
      bit  gap;
      d0           = done_cnt;
      exp_pass_len = 2;
      ready_pct    = 100;
      push_words(8'h20, 2);
      push_words(8'h20, 2);
      push_words(8'h20, 2);
      push_words(8'h20, 2);
      loop      = 1'b1;
      base_addr = 8'h20;
      len       = LW'(2);
      start     = 1'b1;
      tick();
      start = 1'b0;
      dn    = 0;
      gap   = 1'b0;
      for (int c = 0; c < 200; c++) begin
        tick();
        if (done) begin
          dn++;
          if (dn == 3) loop = 1'b0;
          if (dn == 4) break;
          check("loop_busy_at_done", busy, 1);
        end else if (!busy) begin
          gap = 1'b1;
        end
      end
      check("loop_passes", dn, 4);
      check("loop_busy_gap", gap, 0);
      check("loop_final_busy", busy, 0);
      check("loop_queue_empty", exp_q.size(), 0);
      tick();
      check("loop_done_count", done_cnt - d0, 4);
    end
`endif

    // Reset while holding a word in SEND.
    push_words($urandom_range(255), 5);
    exp_pass_len = 5;
    ready_pct    = 0;
    base_addr    = AW'(8'h33);
    len          = LW'(5);
    exp_q.delete();
    push_words(8'h33, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("rst_reach_send", got, 1);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_addr", rom_addr, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("rst_mid_no_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
